// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the decoder's control unit:
// sequencer state encoding, register-index width and base opcodes.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_START    = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_SD   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_ADDI = 7'b0010011;

  // Source-operand usage per opcode, as the control unit derives id_uses_rs2.
  function automatic logic opc_uses_rs2(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_SD) || (opc == OPC_BEQ);
  endfunction

  function automatic logic opc_uses_rs1(input logic [6:0] opc);
    return opc_uses_rs2(opc) || (opc == OPC_LD) || (opc == OPC_ADDI);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes and data-memory freeze,
// with saturating stall/flush counters and a sticky memory-timeout error.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = hazard_pkg::REG_ADDR_W,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  pipe_hold,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       err_set;
  logic       flush_inc;
  logic       stall_inc;
  logic       load_use;

  // x0 is hard-wired zero, so a load targeting it never produces a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_START;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) mem_err <= 1'b1;
    end
  end

  // Outputs are gated by rst_n so nothing is enabled or flushed while reset is held.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    err_set     = 1'b0;
    flush_inc   = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    if (rst_n) begin
      unique case (state)
        ST_START: begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          state_nxt   = ST_RUN;
        end
        ST_RUN: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          if (mem_req && !mem_ready) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            state_nxt  = ST_MEM_WAIT;
            wait_nxt   = 8'd1;
          end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready || (wait_cnt == TIMEOUT_V)) begin
            // Release cycle; a branch held frozen during the wait takes effect now.
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            err_set    = !mem_ready;
            state_nxt  = ST_RUN;
            wait_nxt   = '0;
            if (branch_taken) begin
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
              flush_inc   = 1'b1;
            end
          end else begin
            pipe_hold = 1'b1;
            wait_nxt  = wait_cnt + 8'd1;
          end
        end
        default: state_nxt = ST_START;
      endcase
    end
  end

  assign stall_inc = rst_n && (state != ST_START) && !pc_write;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stimulus pushes hand-computed expectations,
// a monitor pops and compares them once per cycle.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        id_uses_rs2 = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_mem_read = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush;
  logic        pipe_hold, mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .pipe_hold    (pipe_hold),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  // Control word: {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pipe_hold}
  localparam logic [6:0] C_ZERO  = 7'b0000000;
  localparam logic [6:0] C_START = 7'b0001110;
  localparam logic [6:0] C_RUN   = 7'b1100000;
  localparam logic [6:0] C_LU    = 7'b0010000;
  localparam logic [6:0] C_BR    = 7'b1101110;
  localparam logic [6:0] C_HOLD  = 7'b0000001;

  typedef struct {
    logic [6:0]  ctl;
    logic        err;
    logic [15:0] sc;
    logic [15:0] fc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Drive one cycle of inputs at the falling edge and queue what the DUT must show.
  task automatic step(input logic rst, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2, input logic [4:0] rd, input logic mr, input logic br,
                      input logic mq, input logic rdy, input logic [6:0] ctl, input logic err,
                      input int sc, input int fc, input string name);
    exp_t e;
    @(negedge clk);
    rst_n = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; branch_taken = br; mem_req = mq; mem_ready = rdy;
    e.ctl = ctl; e.err = err; e.sc = 16'(sc); e.fc = 16'(fc); e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [6:0] ctl, input logic err, input int sc, input int fc,
                      input string name);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, err, sc, fc, name);
  endtask

  task automatic check(input string name, input logic [6:0] act_ctl, input logic act_err,
                       input logic [15:0] act_sc, input logic [15:0] act_fc, input exp_t e);
    checks++;
    if (act_ctl !== e.ctl || act_err !== e.err || act_sc !== e.sc || act_fc !== e.fc) begin
      failures++;
      $display("FAIL %s: got ctl=%b err=%b stall=%0d flush=%0d, expected ctl=%b err=%b stall=%0d flush=%0d",
               name, act_ctl, act_err, act_sc, act_fc, e.ctl, e.err, e.sc, e.fc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e.name, {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
                       pipe_hold}, mem_err, stall_cnt, flush_cnt, e);
      end
    end
  end

  initial begin : stimulus
    // Reset held, then START, then RUN.
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO, 0, 0, 0, "reset_0");
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO, 0, 0, 0, "reset_1");
    idle(C_START, 0, 0, 0, "start");
    idle(C_RUN, 0, 0, 0, "run_idle");

    // Load-use on rs1, then the bubble has cleared MemRead.
    step(1'b1, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0, C_LU, 0, 0, 0, "lu_rs1");
    step(1'b1, 1, 5'd5, 5'd0, 0, 5'd5, 0, 0, 0, 0, C_RUN, 0, 1, 0, "lu_rs1_after");
    step(1'b1, 1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, C_RUN, 0, 1, 0, "lu_x0");
    step(1'b1, 1, 5'd3, 5'd5, 0, 5'd5, 1, 0, 0, 0, C_RUN, 0, 1, 0, "lu_rs2_unused");
    step(1'b1, 1, 5'd3, 5'd5, 1, 5'd5, 1, 0, 0, 0, C_LU, 0, 1, 0, "lu_rs2_used");
    idle(C_RUN, 0, 2, 0, "lu_rs2_after");
    step(1'b1, 0, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0, C_RUN, 0, 2, 0, "lu_id_invalid");

    // Taken branch overrides a simultaneous load-use.
    step(1'b1, 1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 0, C_BR, 0, 2, 0, "branch_lu");
    idle(C_RUN, 0, 2, 1, "branch_after");

    // Three-cycle memory wait, release on the fourth.
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 0, 2, 1, "mem_stall_1");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 0, 3, 1, "mem_stall_2");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 0, 4, 1, "mem_stall_3");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 5, 1, "mem_release");
    idle(C_RUN, 0, 5, 1, "mem_after");

    // Memory stall outranks a branch; the flush lands on the release cycle.
    step(1'b1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_HOLD, 0, 5, 1, "mem_over_branch");
    step(1'b1, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_BR, 0, 6, 1, "release_branch");
    idle(C_RUN, 0, 6, 2, "release_branch_after");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 6, 2, "mem_ready_same_cycle");

    // Timeout: 15 stalled cycles, forced release, sticky error.
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 0, 6, 2, "tmo_enter");
    for (int k = 1; k <= 14; k++)
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 0, 6 + k, 2, "tmo_wait");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN, 0, 21, 2, "tmo_release");
    idle(C_RUN, 1, 21, 2, "tmo_err_set");
    idle(C_RUN, 1, 21, 2, "tmo_err_sticky");

    // Reset in the middle of a wait clears everything and restarts.
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 1, 21, 2, "rst_wait_enter");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 1, 22, 2, "rst_wait_1");
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ZERO, 0, 0, 0, "rst_mid_wait");
    idle(C_START, 0, 0, 0, "rst_start");
    idle(C_RUN, 0, 0, 0, "rst_run");

    @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
